// File: rtl/ppl_march.sv
// Voxel ray-march step: advances a ray one slope step, reads the world map and
// decides hit / miss / continue with a fixed four-cycle turnaround per ray.
module ppl_march #(
  parameter int          SLOPE_SHIFT = 4,
  parameter logic [3:0]  MAX_STEPS   = 4'd15,
  parameter logic [15:0] SKY_COLOR   = 16'h867D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] start_pos_x,
  input  logic [15:0] start_pos_y,
  input  logic [15:0] start_pos_z,
  input  logic [19:0] ray_slope_x,
  input  logic [19:0] ray_slope_y,
  input  logic [19:0] ray_slope_z,
  input  logic [19:0] pixel_addr,
  input  logic [3:0]  block_cnt,
  output logic        blk_rd,
  output logic [11:0] blk_addr,
  input  logic [7:0]  blk_data,
  output logic        out_valid,
  output logic        next_en,
  output logic [15:0] end_pos_x,
  output logic [15:0] end_pos_y,
  output logic [15:0] end_pos_z,
  output logic [19:0] ray_slope_out_x,
  output logic [19:0] ray_slope_out_y,
  output logic [19:0] ray_slope_out_z,
  output logic [19:0] pixel_addr_out,
  output logic [3:0]  block_cnt_out,
  output logic        pix_we,
  output logic [19:0] pix_addr,
  output logic [15:0] pix_color
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_LOOKUP, S_WAIT} state_t;

  state_t             r_state, w_state_next;
  logic [2:0][15:0]   w_pos_in, r_pos, w_pos_n, r_end_pos;
  logic [2:0][19:0]   w_slope_in, r_slope, r_slope_out;
  logic [2:0]         w_axis_oob;
  logic [19:0]        r_pixel_addr, r_pixel_addr_out, r_pix_addr;
  logic [3:0]         r_block_cnt, r_block_cnt_out;
  logic [15:0]        r_pix_color;
  logic               r_oob, r_out_valid, r_next_en, r_pix_we;
  logic               w_accept, w_decide, w_continue, w_hit;

  assign w_pos_in   = {start_pos_z, start_pos_y, start_pos_x};
  assign w_slope_in = {ray_slope_z, ray_slope_y, ray_slope_x};
  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_decide   = (r_state == S_WAIT);
  assign w_hit      = !r_oob && (blk_data != 8'd0);
  assign w_continue = !r_oob && (blk_data == 8'd0) && (r_block_cnt < MAX_STEPS);

  // 21-bit signed sum: bit 20 flags a negative result, bits 19:16 an overflow past 0xFFFF
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      logic signed [19:0] w_shifted;
      logic signed [20:0] w_sum;
      assign w_shifted      = $signed(r_slope[gi]) >>> SLOPE_SHIFT;
      assign w_sum          = $signed({5'b0, r_pos[gi]}) + $signed({w_shifted[19], w_shifted});
      assign w_pos_n[gi]    = w_sum[15:0];
      assign w_axis_oob[gi] = w_sum[20] | (|w_sum[19:16]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_state_next = S_STEP;
      S_STEP:   w_state_next = S_LOOKUP;
      S_LOOKUP: w_state_next = S_WAIT;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_IDLE);
    blk_rd   = 1'b0;
    blk_addr = '0;
    if (r_state == S_LOOKUP && !r_oob) begin
      blk_rd   = 1'b1;
      blk_addr = {r_pos[0][15:12], r_pos[1][15:12], r_pos[2][15:12]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos            <= '0;
      r_slope          <= '0;
      r_end_pos        <= '0;
      r_slope_out      <= '0;
      r_pixel_addr     <= '0;
      r_block_cnt      <= '0;
      r_oob            <= 1'b0;
      r_out_valid      <= 1'b0;
      r_next_en        <= 1'b0;
      r_pix_we         <= 1'b0;
      r_pixel_addr_out <= '0;
      r_block_cnt_out  <= '0;
      r_pix_addr       <= '0;
      r_pix_color      <= '0;
    end else begin
      r_out_valid <= w_decide;
      r_pix_we    <= w_decide && !w_continue;
      if (w_accept) begin
        r_pos        <= w_pos_in;
        r_slope      <= w_slope_in;
        r_pixel_addr <= pixel_addr;
        r_block_cnt  <= block_cnt;
      end
      if (r_state == S_STEP) begin
        r_pos <= w_pos_n;
        r_oob <= |w_axis_oob;
      end
      if (w_decide) begin
        r_next_en        <= !w_continue;
        r_end_pos        <= r_pos;
        r_slope_out      <= r_slope;
        r_pixel_addr_out <= r_pixel_addr;
        r_block_cnt_out  <= w_continue ? r_block_cnt + 4'd1 : r_block_cnt;
        // Framebuffer fields only move when the ray terminates
        if (!w_continue) begin
          r_pix_addr  <= r_pixel_addr;
          r_pix_color <= w_hit ? {blk_data, ~r_block_cnt, 4'h0} : SKY_COLOR;
        end
      end
    end
  end

  assign out_valid       = r_out_valid;
  assign next_en         = r_next_en;
  assign end_pos_x       = r_end_pos[0];
  assign end_pos_y       = r_end_pos[1];
  assign end_pos_z       = r_end_pos[2];
  assign ray_slope_out_x = r_slope_out[0];
  assign ray_slope_out_y = r_slope_out[1];
  assign ray_slope_out_z = r_slope_out[2];
  assign pixel_addr_out  = r_pixel_addr_out;
  assign block_cnt_out   = r_block_cnt_out;
  assign pix_we          = r_pix_we;
  assign pix_addr        = r_pix_addr;
  assign pix_color       = r_pix_color;

endmodule

// File: tb/tb_ppl_march.sv
// Self-checking bench for ppl_march: directed corner rays, a mid-flight reset,
// then random rays against an arithmetic reference model and a random world map.
module tb_ppl_march;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] start_pos_x = '0, start_pos_y = '0, start_pos_z = '0;
  logic [19:0] ray_slope_x = '0, ray_slope_y = '0, ray_slope_z = '0;
  logic [19:0] pixel_addr = '0;
  logic [3:0]  block_cnt = '0;
  logic        blk_rd;
  logic [11:0] blk_addr;
  logic [7:0]  blk_data = '0;
  logic        out_valid, next_en, pix_we;
  logic [15:0] end_pos_x, end_pos_y, end_pos_z, pix_color;
  logic [19:0] ray_slope_out_x, ray_slope_out_y, ray_slope_out_z;
  logic [19:0] pixel_addr_out, pix_addr;
  logic [3:0]  block_cnt_out;

  ppl_march dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .start_pos_x(start_pos_x), .start_pos_y(start_pos_y), .start_pos_z(start_pos_z),
    .ray_slope_x(ray_slope_x), .ray_slope_y(ray_slope_y), .ray_slope_z(ray_slope_z),
    .pixel_addr(pixel_addr), .block_cnt(block_cnt),
    .blk_rd(blk_rd), .blk_addr(blk_addr), .blk_data(blk_data),
    .out_valid(out_valid), .next_en(next_en),
    .end_pos_x(end_pos_x), .end_pos_y(end_pos_y), .end_pos_z(end_pos_z),
    .ray_slope_out_x(ray_slope_out_x), .ray_slope_out_y(ray_slope_out_y),
    .ray_slope_out_z(ray_slope_out_z),
    .pixel_addr_out(pixel_addr_out), .block_cnt_out(block_cnt_out),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_color(pix_color)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0][15:0] pos;
    logic [2:0][19:0] slope;
    logic [19:0]      pix;
    logic [3:0]       cnt;
  } ray_t;

  typedef struct {
    bit               oob;
    logic [2:0][15:0] ep;
    logic [11:0]      addr;
    bit               term;
    logic [3:0]       cnt_out;
    logic [15:0]      color;
  } exp_t;

  logic [7:0] world [4096];
  int n_checks = 0, n_pass = 0, n_fail = 0;
  bit          have_prev = 0;
  logic        prev_next_en;
  logic [15:0] prev_ep_x;
  logic [3:0]  prev_cnt_out;

  // World-map memory: data appears one cycle after a read strobe, junk otherwise
  logic        pend_rd = 1'b0;
  logic [11:0] pend_addr = '0;
  always @(negedge clk) begin
    pend_rd   = blk_rd;
    pend_addr = blk_addr;
  end
  always @(posedge clk) begin
    #1;
    blk_data = pend_rd ? world[pend_addr] : 8'($urandom);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: floor-divide the slope by 16, add to position, classify by world contents
  function automatic exp_t model(input ray_t r);
    exp_t e;
    int s, q, n;
    logic [7:0] d;
    e.oob = 0;
    for (int i = 0; i < 3; i++) begin
      s = int'(r.slope[i]);
      if (r.slope[i][19]) s = s - (1 << 20);
      q = (s >= 0) ? s / 16 : -((-s + 15) / 16);
      n = int'(r.pos[i]) + q;
      if (n < 0 || n > 65535) e.oob = 1;
      e.ep[i] = 16'(n);
    end
    e.addr = 12'((e.ep[0] / 4096) * 256 + (e.ep[1] / 4096) * 16 + (e.ep[2] / 4096));
    e.cnt_out = r.cnt;
    e.term = 1;
    e.color = 16'h867D;
    if (!e.oob) begin
      d = world[e.addr];
      if (d != 0) e.color = 16'(int'(d) * 256 + (15 - int'(r.cnt)) * 16);
      else if (r.cnt < 15) begin
        e.term = 0;
        e.cnt_out = r.cnt + 4'd1;
      end
    end
    return e;
  endfunction

  task automatic drive(input ray_t r);
    start_pos_x = r.pos[0]; start_pos_y = r.pos[1]; start_pos_z = r.pos[2];
    ray_slope_x = r.slope[0]; ray_slope_y = r.slope[1]; ray_slope_z = r.slope[2];
    pixel_addr = r.pix;
    block_cnt = r.cnt;
  endtask

  task automatic drive_junk();
    ray_t j;
    for (int i = 0; i < 3; i++) begin
      j.pos[i] = 16'($urandom);
      j.slope[i] = 20'($urandom);
    end
    j.pix = 20'($urandom);
    j.cnt = 4'($urandom);
    drive(j);
  endtask

  // Called at a negedge with the block idle; returns at the negedge where out_valid is seen
  task automatic run_ray(input ray_t r, input string nm);
    exp_t e;
    int lat, rd_cnt;
    bit got;
    logic [11:0] seen_addr;
    e = model(r);
    drive(r);
    in_valid = 1'b1;
    check({nm, "/in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    drive_junk();
    got = 0; lat = 0; rd_cnt = 0; seen_addr = '0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (blk_rd) begin
        rd_cnt++;
        seen_addr = blk_addr;
      end
      if (out_valid) begin
        got = 1;
        lat = k;
      end else if (k == 1 && have_prev) begin
        check({nm, "/hold_next_en"}, next_en, prev_next_en);
        check({nm, "/hold_end_x"}, end_pos_x, prev_ep_x);
        check({nm, "/hold_cnt"}, block_cnt_out, prev_cnt_out);
        check({nm, "/pix_we_pulse"}, pix_we, 0);
      end
    end
    check({nm, "/latency"}, lat, 4);
    if (got) begin
      check({nm, "/next_en"}, next_en, e.term);
      check({nm, "/pix_we"}, pix_we, e.term);
      check({nm, "/block_cnt_out"}, block_cnt_out, e.cnt_out);
      check({nm, "/end_pos"}, {end_pos_z, end_pos_y, end_pos_x}, e.ep);
      check({nm, "/slope_out"}, {ray_slope_out_z, ray_slope_out_y, ray_slope_out_x}, r.slope);
      check({nm, "/pixel_addr_out"}, pixel_addr_out, r.pix);
      check({nm, "/blk_rd_count"}, rd_cnt, e.oob ? 0 : 1);
      if (!e.oob) check({nm, "/blk_addr"}, seen_addr, e.addr);
      if (e.term) begin
        check({nm, "/pix_addr"}, pix_addr, r.pix);
        check({nm, "/pix_color"}, pix_color, e.color);
      end
    end
    in_valid = 1'b0;
    have_prev = 1;
    prev_next_en = e.term;
    prev_ep_x = e.ep[0];
    prev_cnt_out = e.cnt_out;
  endtask

  initial begin
    ray_t base, r;
    for (int i = 0; i < 4096; i++) world[i] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/in_ready", in_ready, 1);
    check("rst/out_valid", out_valid, 0);
    check("rst/next_en", next_en, 0);
    check("rst/blk_rd", blk_rd, 0);
    check("rst/pix_we", pix_we, 0);
    check("rst/data", {pix_color, end_pos_x, block_cnt_out, pix_addr}, 0);
    rst = 1'b1;

    base.pos = {16'h1000, 16'h1000, 16'h1000};
    base.slope = {20'h0, 20'h0, 20'h00100};
    base.pix = 20'h12345;
    base.cnt = 4'd0;

    world[12'h111] = 8'h00;
    run_ray(base, "step_air");
    check("step_air/end_x_const", end_pos_x, 16'h1010);
    check("step_air/cnt_const", block_cnt_out, 4'd1);

    world[12'h111] = 8'h2A;
    run_ray(base, "hit");
    check("hit/color_const", pix_color, 16'h2AF0);

    world[12'h111] = 8'h00;
    r = base; r.cnt = 4'd15;
    run_ray(r, "max_steps");
    check("max_steps/color_const", pix_color, 16'h867D);

    r = base; r.pos[0] = 16'h0005; r.slope[0] = 20'hFFF00;
    run_ray(r, "oob_neg");
    r = base; r.pos[0] = 16'hFFF0; r.slope[0] = 20'h00200;
    run_ray(r, "oob_pos");

    // Reset while the ray sits in WAIT: nothing may emerge
    world[12'h111] = 8'h2A;
    drive(base);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst/out_valid", out_valid, 0);
    check("midrst/pix_we", pix_we, 0);
    check("midrst/next_en", next_en, 0);
    check("midrst/blk_rd", blk_rd, 0);
    check("midrst/in_ready", in_ready, 1);
    check("midrst/data", {pix_color, end_pos_x, block_cnt_out, pix_addr}, 0);
    @(posedge clk);
    #1;
    check("midrst/no_pulse", {out_valid, pix_we}, 0);
    @(negedge clk);
    rst = 1'b1;
    have_prev = 0;
    run_ray(base, "post_rst");

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 3; i++) begin
        r.pos[i] = 16'($urandom);
        if ($urandom_range(0, 3) == 0) r.slope[i] = 20'($urandom);
        else r.slope[i] = 20'($urandom_range(0, 8191) - 4096);
      end
      r.pix = 20'($urandom);
      r.cnt = 4'($urandom);
      run_ray(r, $sformatf("rnd%0d", t));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ppl_march.md
PPL_MARCH -- requirements
Module: ppl_march

Interface
REQ-001 Parameter SLOPE_SHIFT, default 4: arithmetic right shift applied to ray slope per step.
REQ-002 Parameter MAX_STEPS, default 15: block_cnt value at which a non-hit ray terminates as a miss.
REQ-003 Parameter SKY_COLOR, default 16'h867D: RGB565 colour written for miss / out-of-world rays.
REQ-004 clk  input  1  sole clock, all state rising-edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 in_valid  input  1  ray inputs valid this cycle.
REQ-007 in_ready  output  1  block can accept a ray (high only in IDLE).
REQ-008 start_pos_x/y/z  input  16 each  unsigned Q4.12 ray position.
REQ-009 ray_slope_x/y/z  input  20 each  signed ray direction.
REQ-010 pixel_addr  input  20  framebuffer address of ray.
REQ-011 block_cnt  input  4  steps already taken.
REQ-012 blk_rd  output  1  world-map read strobe.
REQ-013 blk_addr  output  12  world-map address {x[15:12], y[15:12], z[15:12]}.
REQ-014 blk_data  input  8  block id, valid the cycle after blk_rd; 0 = air.
REQ-015 out_valid  output  1  one-cycle pulse, all *_out and next_en valid.
REQ-016 next_en  output  1  1 = ray terminated, upstream issues new ray; 0 = ray continues.
REQ-017 end_pos_x/y/z  output  16 each  advanced position.
REQ-018 ray_slope_out_x/y/z  output  20 each  slope passed through unchanged.
REQ-019 pixel_addr_out  output  20  pixel address passed through.
REQ-020 block_cnt_out  output  4  updated step count.
REQ-021 pix_we  output  1  framebuffer write strobe; pix_addr  output  20; pix_color  output  16.

Function
REQ-022 FSM states IDLE, STEP, LOOKUP, WAIT; IDLE->STEP when in_valid&&in_ready; STEP->LOOKUP->WAIT->IDLE unconditionally.
REQ-023 In IDLE on accept, register all ray inputs; in_valid while not IDLE is ignored, with no effect on state.
REQ-024 STEP: per axis, pos_n = zero-ext(pos) + sign-ext(slope >>> SLOPE_SHIFT), computed 21-bit signed; register low 16 bits; set oob flag if any axis result < 0 or > 65535.
REQ-025 LOOKUP: blk_rd=1 and blk_addr from registered position only when oob=0; blk_rd=0 otherwise.
REQ-026 WAIT: sample blk_data; at the WAIT->IDLE edge register the decision, driving out_valid=1 for exactly the following cycle.
REQ-027 Hit (oob=0, blk_data!=0): next_en=1, pix_we=1, pix_color={blk_data, ~block_cnt, 4'h0}.
REQ-028 Miss (oob=1, or blk_data==0 with block_cnt>=MAX_STEPS): next_en=1, pix_we=1, pix_color=SKY_COLOR.
REQ-029 Continue (oob=0, blk_data==0, block_cnt<MAX_STEPS): next_en=0, pix_we=0, block_cnt_out=block_cnt+1.
REQ-030 On hit/miss, block_cnt_out=block_cnt (no increment); pix_addr=pixel_addr_out=latched pixel_addr.
REQ-031 Latency fixed: out_valid 4 cycles after the accept edge, independent of oob.
REQ-032 A new ray is acceptable in the same cycle out_valid is high (state already IDLE); throughput one ray per 4 cycles.
REQ-033 *_out, end_pos, next_en hold their value after out_valid until the next decision.
REQ-034 blk_data is ignored when blk_rd was not asserted for that ray.

Reset
REQ-035 rst=0 forces IDLE asynchronously; in-flight ray discarded with no out_valid or pix_we.
REQ-036 Reset values: in_ready=1 after release, out_valid=0, next_en=0, blk_rd=0, pix_we=0, all data outputs 0.
REQ-037 First accept possible on the first rising edge with rst=1.

Verification
REQ-038 pos=(0x1000,0x1000,0x1000), slope=(0x100,0,0), cnt=0, blk_data=0 -> blk_addr=0x111, end_pos_x=0x1010, next_en=0, block_cnt_out=1, out_valid 4 cycles after accept.
REQ-039 Same ray with blk_data=0x2A -> next_en=1, pix_we=1, pix_color=16'h2AF0, pix_addr=pixel_addr.
REQ-040 cnt=15, blk_data=0 -> next_en=1, pix_color=16'h867D, block_cnt_out=15.
REQ-041 pos_x=0x0005, slope_x=-0x100 -> oob, blk_rd never asserted, miss with SKY_COLOR; pos_x=0xFFF0, slope_x=0x200 -> same.
REQ-042 Back-to-back: in_valid held high -> second ray accepted in the out_valid cycle; in_valid during STEP/LOOKUP/WAIT ignored.
REQ-043 rst=0 asserted during WAIT -> outputs zero immediately, no out_valid/pix_we; next ray after release processes normally.
